// File: rtl/fpga_cfg_loader.sv
// Configuration-chain loader: accepts bytes over a valid/ready stream, shifts them LSB first
// into a flip-flop chain of CHAIN_LEN bits, then verifies a trailing XOR checksum byte.

module fpga_cfg_loader_chk (
    input logic clk,
    input logic rst_n,
    input logic cfg_en,
    input logic in_ready,
    input logic busy,
    input logic done,
    input logic error
);

    a_cfg_en_busy : assert property (@(posedge clk) disable iff (!rst_n) cfg_en |-> busy);
    a_ready_busy  : assert property (@(posedge clk) disable iff (!rst_n) in_ready |-> busy);
    a_ready_shift : assert property (@(posedge clk) disable iff (!rst_n) !(in_ready && cfg_en));
    a_done_error  : assert property (@(posedge clk) disable iff (!rst_n) !(done && error));

endmodule

module fpga_cfg_loader #(
    parameter int CHAIN_LEN = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ccff_head,
    output logic       cfg_en,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int BL_W = $clog2(CHAIN_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t          state_r, state_s;
    logic [BL_W-1:0] bits_left_r, bits_left_s;
    logic [7:0]      checksum_r, checksum_s;
    logic [7:0]      shreg_r, shreg_s;
    logic [2:0]      bit_idx_r, bit_idx_s;
    logic            ccff_head_r, ccff_head_s;
    logic            cfg_en_r, cfg_en_s;
    logic            in_ready_r, in_ready_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic            error_r, error_s;
    logic            xfer_s;
    logic            last_bit_s;

    assign xfer_s     = in_valid & in_ready_r;
    // A byte ends early when the chain runs out, so the upper bits of a partial byte are never shifted.
    assign last_bit_s = (bit_idx_r == 3'd7) || (bits_left_r == BL_W'(1));

    // Next-state and next-output logic; every output is the registered image of its _s value.
    always_comb begin
        state_s     = state_r;
        bits_left_s = bits_left_r;
        checksum_s  = checksum_r;
        shreg_s     = shreg_r;
        bit_idx_s   = bit_idx_r;
        ccff_head_s = ccff_head_r;
        cfg_en_s    = 1'b0;
        in_ready_s  = in_ready_r;
        busy_s      = busy_r;
        done_s      = done_r;
        error_s     = error_r;

        if (abort) begin
            state_s    = ST_IDLE;
            in_ready_s = 1'b0;
            busy_s     = 1'b0;
            done_s     = 1'b0;
            error_s    = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_s     = ST_LOAD;
                        bits_left_s = BL_W'(CHAIN_LEN);
                        checksum_s  = 8'h00;
                        in_ready_s  = 1'b1;
                        busy_s      = 1'b1;
                        done_s      = 1'b0;
                        error_s     = 1'b0;
                    end else begin
                        in_ready_s = 1'b0;
                        busy_s     = 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (xfer_s) begin
                        state_s     = ST_SHIFT;
                        shreg_s     = in_data;
                        checksum_s  = csum_update(checksum_r, in_data);
                        bit_idx_s   = 3'd0;
                        ccff_head_s = in_data[0];
                        cfg_en_s    = 1'b1;
                        in_ready_s  = 1'b0;
                    end else begin
                        in_ready_s = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // bits_left is at least 1 here, so this decrement cannot wrap.
                    bits_left_s = bits_left_r - BL_W'(1);
                    if (last_bit_s) begin
                        in_ready_s = 1'b1;
                        if (bits_left_r == BL_W'(1)) begin
                            state_s = ST_CHECK;
                        end else begin
                            state_s = ST_LOAD;
                        end
                    end else begin
                        bit_idx_s   = bit_idx_r + 3'd1;
                        ccff_head_s = shreg_r[bit_idx_s];
                        cfg_en_s    = 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (xfer_s) begin
                        in_ready_s = 1'b0;
                        busy_s     = 1'b0;
                        if (in_data == checksum_r) begin
                            state_s = ST_DONE;
                            done_s  = 1'b1;
                        end else begin
                            state_s = ST_ERR;
                            error_s = 1'b1;
                        end
                    end else begin
                        in_ready_s = 1'b1;
                    end
                end
                default: begin
                    state_s    = ST_IDLE;
                    in_ready_s = 1'b0;
                    busy_s     = 1'b0;
                    done_s     = 1'b0;
                    error_s    = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            bits_left_r <= '0;
            checksum_r  <= 8'h00;
            shreg_r     <= 8'h00;
            bit_idx_r   <= 3'd0;
            ccff_head_r <= 1'b0;
            cfg_en_r    <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            bits_left_r <= bits_left_s;
            checksum_r  <= checksum_s;
            shreg_r     <= shreg_s;
            bit_idx_r   <= bit_idx_s;
            ccff_head_r <= ccff_head_s;
            cfg_en_r    <= cfg_en_s;
            in_ready_r  <= in_ready_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            error_r     <= error_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign ccff_head = ccff_head_r;
    assign cfg_en    = cfg_en_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign error     = error_r;

    fpga_cfg_loader_chk u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_en   (cfg_en_r),
        .in_ready (in_ready_r),
        .busy     (busy_r),
        .done     (done_r),
        .error    (error_r)
    );

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Scoreboard bench for fpga_cfg_loader with a 12-bit chain: drivers queue expected chain bits
// and load outcomes, independent monitors pop and compare them as the DUT presents outputs.

module tb_fpga_cfg_loader;

    localparam int CL = 12;
    localparam int NB = (CL + 7) / 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ccff_head;
    logic       cfg_en;
    logic       busy;
    logic       done;
    logic       error;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   bit_q[$];
    logic [1:0] res_q[$];
    int   cfg_cnt = 0;
    int   xfer_cnt = 0;

    fpga_cfg_loader #(.CHAIN_LEN(CL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ccff_head (ccff_head),
        .cfg_en    (cfg_en),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transfers happen on rising edges where valid and ready were both high beforehand.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && in_valid && in_ready) xfer_cnt++;
        end
    end

    // Output monitor: chain bits and load outcomes against the scoreboard queues.
    initial begin
        bit         exp_b;
        logic [1:0] exp_r;
        logic       done_p;
        logic       error_p;
        done_p  = 1'b0;
        error_p = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cfg_en) begin
                    cfg_cnt++;
                    check("ready_low_in_shift", in_ready, 1'b0);
                    if (bit_q.size() == 0) begin
                        check("unexpected_cfg_en", 1, 0);
                    end else begin
                        exp_b = bit_q.pop_front();
                        check("ccff_head", ccff_head, exp_b);
                    end
                end
                if ((done && !done_p) || (error && !error_p)) begin
                    if (res_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        exp_r = res_q.pop_front();
                        check("done_error", {done, error}, exp_r);
                    end
                    check("cfg_en_cycles", cfg_cnt, CL);
                    check("bits_pending", bit_q.size(), 0);
                end
                done_p  = done;
                error_p = error;
            end else begin
                done_p  = 1'b0;
                error_p = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit hold);
        bit took;
        int t;
        took = 1'b0;
        t    = 0;
        while (!took && t < 300) begin
            in_valid = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_data  = in_valid ? b : 8'($urandom);
            took     = in_valid && in_ready;
            @(negedge clk);
            t++;
        end
        if (!took) check("byte_accept_timeout", 0, 1);
        if (!hold) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("idle_timeout", 0, 1);
    endtask

    task automatic begin_load();
        cfg_cnt = 0;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_ready", in_ready, 1'b1);
        check("start_clears", {done, error}, 2'b00);
    endtask

    // One complete load; the model derives chain bits and checksum straight from the byte list.
    task automatic do_load(input bit fixed, input bit bad, input bit hold, input bit noisy);
        logic [7:0] dbytes[NB];
        logic [7:0] chk;
        logic [7:0] sent;
        chk = 8'h00;
        for (int i = 0; i < NB; i++) begin
            dbytes[i] = 8'($urandom);
            chk       = chk ^ dbytes[i];
        end
        if (fixed) begin
            dbytes[0] = 8'hA5;
            dbytes[1] = 8'h3C;
            chk       = 8'h99;
        end
        for (int i = 0; i < CL; i++) bit_q.push_back(dbytes[i / 8][i % 8]);
        if (fixed && bad) sent = 8'h98;
        else if (bad)     sent = chk ^ (8'h01 << $urandom_range(0, 7));
        else              sent = chk;
        res_q.push_back(bad ? 2'b01 : 2'b10);
        begin_load();
        if (noisy) start = 1'b1;
        for (int i = 0; i < NB; i++) send_byte(dbytes[i], hold);
        send_byte(sent, hold);
        start = 1'b0;
        wait_idle();
        @(negedge clk);
        check("final_done", done, !bad);
        check("final_error", error, bad);
    endtask

    initial begin
        int x0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        #23;
        check("rst_outputs", {ccff_head, cfg_en, in_ready, busy, done, error}, 6'b0);
        #4 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_outputs", {cfg_en, in_ready, busy, done, error}, 5'b0);

        // in_valid while idle must not consume anything
        x0       = xfer_cnt;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (4) @(negedge clk);
        check("idle_ready", in_ready, 1'b0);
        check("idle_no_xfer", xfer_cnt - x0, 0);
        in_valid = 1'b0;

        do_load(1'b1, 1'b0, 1'b0, 1'b0);
        do_load(1'b1, 1'b1, 1'b0, 1'b0);
        do_load(1'b1, 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 8; n++)
            do_load(1'b0, ($urandom_range(0, 2) == 0), 1'b0, ($urandom_range(0, 1) == 1));

        // valid held high across the whole load
        x0 = xfer_cnt;
        do_load(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        check("hold_ready_after", in_ready, 1'b0);
        check("hold_xfer_count", xfer_cnt - x0, NB + 1);
        in_valid = 1'b0;

        // abort on the fourth shift cycle of the first byte
        for (int i = 0; i < CL; i++) bit_q.push_back(1'b0);
        begin_load();
        send_byte(8'h00, 1'b0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_outputs", {cfg_en, in_ready, busy, done, error}, 5'b0);
        check("abort_bits_shifted", CL - bit_q.size(), 4);
        bit_q.delete();
        repeat (2) @(negedge clk);
        check("abort_stays_idle", busy, 1'b0);
        do_load(1'b1, 1'b0, 1'b0, 1'b0);

        // asynchronous reset in the middle of shifting
        for (int i = 0; i < CL; i++) bit_q.push_back(1'b1);
        begin_load();
        send_byte(8'hFF, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {ccff_head, cfg_en, in_ready, busy, done, error}, 6'b0);
        bit_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_quiet", {cfg_en, busy}, 2'b00);
        do_load(1'b1, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("bit_q_empty", bit_q.size(), 0);
        check("res_q_empty", res_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
